// File: rtl/vfd_video_out.sv
// VFD scan-out stage: VGA 640x480 timing, linear VRAM fetch and RGB332 to RGB888 expansion.
// Sync/blank flags travel through the same two-ce pipe as the fetched pixel so they stay aligned.
module vfd_video_out #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  output logic [18:0] vram_addr,
  output logic        vram_rd,
  input  logic [7:0]  vram_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hs,
  output logic        vs,
  output logic        hblank,
  output logic        vblank,
  output logic        de
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HC_ACT_END  = 10'(H_ACTIVE);
  localparam logic [9:0] HC_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HC_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HC_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] VC_ACT_END  = 10'(V_ACTIVE);
  localparam logic [9:0] VC_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VC_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VC_LAST     = 10'(V_TOTAL - 1);

  logic [9:0]  r_hc;
  logic [9:0]  r_vc;
  logic [18:0] r_addr;
  logic [7:0]  r_pix_q;
  logic        r_s1_hact;
  logic        r_s1_vact;
  logic        r_s1_hsync;
  logic        r_s1_vsync;

  logic        w_hact;
  logic        w_vact;
  logic        w_hsync;
  logic        w_vsync;
  logic        w_fetch;
  logic        w_h_wrap;
  logic        w_v_wrap;
  logic        w_s1_de;
  logic [2:0]  w_r3;
  logic [2:0]  w_g3;
  logic [1:0]  w_b2;
  logic [7:0]  w_red;
  logic [7:0]  w_green;
  logic [7:0]  w_blue;

  assign w_hact   = (r_hc < HC_ACT_END);
  assign w_vact   = (r_vc < VC_ACT_END);
  assign w_hsync  = (r_hc >= HC_SYNC_BEG) && (r_hc < HC_SYNC_END);
  assign w_vsync  = (r_vc >= VC_SYNC_BEG) && (r_vc < VC_SYNC_END);
  assign w_fetch  = w_hact && w_vact;
  assign w_h_wrap = (r_hc == HC_LAST);
  assign w_v_wrap = (r_vc == VC_LAST);
  assign w_s1_de  = r_s1_hact && r_s1_vact;

  // Replicate the narrow fields so full-scale codes reach 8'hFF.
  assign w_r3    = r_pix_q[7:5];
  assign w_g3    = r_pix_q[4:2];
  assign w_b2    = r_pix_q[1:0];
  assign w_red   = {w_r3, w_r3, w_r3[2:1]};
  assign w_green = {w_g3, w_g3, w_g3[2:1]};
  assign w_blue  = {w_b2, w_b2, w_b2, w_b2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hc <= '0;
      r_vc <= '0;
    end else if (ce_pix) begin
      if (w_h_wrap) begin
        r_hc <= '0;
        r_vc <= w_v_wrap ? '0 : r_vc + 10'd1;
      end else begin
        r_hc <= r_hc + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      vram_addr <= '0;
      vram_rd   <= 1'b0;
    end else begin
      vram_rd <= 1'b0;
      if (ce_pix) begin
        if (w_fetch) begin
          vram_addr <= r_addr;
          vram_rd   <= 1'b1;
          r_addr    <= r_addr + 19'd1;
        end else if (w_h_wrap && w_v_wrap) begin
          r_addr <= '0;
        end
      end
    end
  end

  // Capture is keyed to the strobe, not to ce, so data lands before the next ce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_q <= '0;
    end else if (vram_rd) begin
      r_pix_q <= vram_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_hact  <= 1'b0;
      r_s1_vact  <= 1'b0;
      r_s1_hsync <= 1'b0;
      r_s1_vsync <= 1'b0;
      hs         <= 1'b1;
      vs         <= 1'b1;
      hblank     <= 1'b1;
      vblank     <= 1'b1;
      de         <= 1'b0;
      red        <= '0;
      green      <= '0;
      blue       <= '0;
    end else if (ce_pix) begin
      r_s1_hact  <= w_hact;
      r_s1_vact  <= w_vact;
      r_s1_hsync <= w_hsync;
      r_s1_vsync <= w_vsync;
      hs         <= ~r_s1_hsync;
      vs         <= ~r_s1_vsync;
      hblank     <= ~r_s1_hact;
      vblank     <= ~r_s1_vact;
      de         <= w_s1_de;
      red        <= w_s1_de ? w_red   : '0;
      green      <= w_s1_de ? w_green : '0;
      blue       <= w_s1_de ? w_blue  : '0;
    end
  end

endmodule
